switch_enter_capture: RTL and testbench



---
 rtl/swcap_pkg.sv | 14 +
 rtl/debounce_sync.sv | 52 +++++
 rtl/switch_enter_capture.sv | 158 +++++++++++++++
 tb/tb_switch_enter_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/swcap_pkg.sv
// Shared constants for the switch/enter capture path: MMIO addresses
// and status-word bit positions.
package swcap_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_ENTER     = 3;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/debounce_sync.sv
// Single-bit 2-flop synchroniser followed by a stability counter.
// The level toggles after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_fire;

    assign w_diff = r_s2 ^ r_level;
    assign w_fire = w_diff && (r_cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_fire) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Pulses coincide with the edge on which r_level flips.
    assign o_level = r_level;
    assign o_rise  = w_fire & r_s2;
    assign o_fall  = w_fire & ~r_s2;

endmodule

// File: rtl/switch_enter_capture.sv
// Captures the switch word on each debounced enter press into a small FIFO
// drained over MMIO. Define SW_CAPTURE_ECHO_EN to add the echo_led output.
module switch_enter_capture
    import swcap_pkg::*;
#(
    parameter int DATA_W          = 16,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_enter,
    input  logic              rd_en,
    input  logic              rd_addr,
    input  logic              ovf_clr,
    output logic [31:0]       rd_data,
    output logic              data_avail,
`ifdef SW_CAPTURE_ECHO_EN
    output logic [DATA_W-1:0] echo_led,
`endif
    output logic              wait_led
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] r_d1;
    logic [DATA_W-1:0] r_d2;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_ovf;

    logic              w_level;
    logic              w_rise;
    logic              w_fall;
    logic              w_level_nxt;
    logic              w_empty;
    logic              w_full;
    logic              w_pop_req;
    logic              w_stat_req;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_set;
    logic [CW-1:0]     w_count_nxt;
    logic [31:0]       w_status;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter (
        .clock  (clock),
        .reset  (reset),
        .i_raw  (sw_enter),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop_req  = rd_en && (rd_addr == ADDR_DATA);
    assign w_stat_req = rd_en && (rd_addr == ADDR_STATUS);
    assign w_pop      = w_pop_req && !w_empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign w_push     = w_rise && (!w_full || w_pop);
    assign w_ovf_set  = w_rise && w_full && !w_pop;

    always_comb begin
        w_level_nxt = w_level;
        if (w_rise) begin
            w_level_nxt = 1'b1;
        end else if (w_fall) begin
            w_level_nxt = 1'b0;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_comb begin
        w_status = '0;
        w_status[ST_COUNT_LSB +: 8] = 8'(r_count);
        w_status[ST_ENTER]          = w_level;
        w_status[ST_OVF]            = r_ovf;
        w_status[ST_FULL]           = w_full;
        w_status[ST_EMPTY]          = w_empty;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_d1 <= '0;
            r_d2 <= '0;
        end else begin
            r_d1 <= sw_data;
            r_d2 <= r_d1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_tail] <= r_d2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            rd_data    <= '0;
            data_avail <= 1'b0;
            wait_led   <= 1'b1;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= w_count_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_pop) begin
                rd_data <= 32'(r_mem[r_head]);
            end else if (w_pop_req) begin
                rd_data <= '0;
            end else if (w_stat_req) begin
                rd_data <= w_status;
            end
            data_avail <= (w_count_nxt != '0);
            wait_led   <= (w_count_nxt == '0) && !w_level_nxt;
        end
    end

`ifdef SW_CAPTURE_ECHO_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_led <= '0;
        end else if (w_pop) begin
            echo_led <= r_mem[r_head];
        end
    end
`endif

endmodule

// File: tb/tb_switch_enter_capture.sv
// Directed bench for switch_enter_capture with a queue-based reference model.
module tb_switch_enter_capture;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int DB    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] sw_data = '0;
    logic          sw_enter = 1'b0;
    logic          rd_en = 1'b0;
    logic          rd_addr = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [31:0]   rd_data;
    logic          data_avail;
    logic          wait_led;
`ifdef SW_CAPTURE_ECHO_EN
    logic [DW-1:0] echo_led;
`endif

    int errors = 0;
    int checks = 0;
    bit started = 0;

    always #5 clk = ~clk;

    switch_enter_capture #(
        .DATA_W(DW),
        .DEPTH(DEPTH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clock(clk),
        .reset(rst),
        .sw_data(sw_data),
        .sw_enter(sw_enter),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .ovf_clr(ovf_clr),
        .rd_data(rd_data),
        .data_avail(data_avail),
`ifdef SW_CAPTURE_ECHO_EN
        .echo_led(echo_led),
`endif
        .wait_led(wait_led)
    );

    // Reference model: sync delay line, run-length debounce, queue FIFO.
    logic [DW-1:0] q[$];
    bit            m_ovf, m_db, e1, e2, rise;
    int            m_run;
    logic [DW-1:0] d1, d2, w;
    logic [31:0]   m_rd, st;
    bit            m_av, m_wl;
    logic [DW-1:0] m_echo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 0; m_db = 0; m_run = 0;
            e1 = 0; e2 = 0; d1 = '0; d2 = '0;
            m_rd = '0; m_av = 0; m_wl = 1; m_echo = '0;
        end else begin
            st = (32'(q.size()) << 8)
               | {28'h0, m_db, m_ovf, (q.size() == DEPTH), (q.size() == 0)};
            rise = 0;
            if (e2 != m_db) begin
                m_run++;
                if (m_run == DB) begin
                    m_db = e2;
                    m_run = 0;
                    rise = e2;
                end
            end else begin
                m_run = 0;
            end
            if (rd_en && rd_addr) begin
                m_rd = st;
            end else if (rd_en) begin
                if (q.size() > 0) begin
                    w = q.pop_front();
                    m_rd = {16'h0, w};
                    m_echo = w;
                end else begin
                    m_rd = '0;
                end
            end
            if (ovf_clr) m_ovf = 0;
            if (rise) begin
                if (q.size() < DEPTH) q.push_back(d2);
                else m_ovf = 1;
            end
            m_av = (q.size() > 0);
            m_wl = (q.size() == 0) && !m_db;
            e2 = e1; e1 = sw_enter;
            d2 = d1; d1 = sw_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model rd_data", rd_data, m_rd);
            chk("model data_avail", 32'(data_avail), 32'(m_av));
            chk("model wait_led", 32'(wait_led), 32'(m_wl));
`ifdef SW_CAPTURE_ECHO_EN
            chk("model echo_led", 32'(echo_led), 32'(m_echo));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic a);
        rd_en = 1'b1;
        rd_addr = a;
        cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic press(input logic [DW-1:0] d);
        sw_data = d;
        sw_enter = 1'b1;
        cyc(8);
        sw_enter = 1'b0;
        cyc(8);
    endtask

    initial begin
        #1 rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        started = 1;
        chk("reset rd_data", rd_data, 32'h0);
        chk("reset data_avail", 32'(data_avail), 32'h0);
        chk("reset wait_led", 32'(wait_led), 32'h1);

        // Single press held for 10 cycles
        sw_data = 16'h0001;
        sw_enter = 1'b1;
        cyc(10);
        chk("press data_avail", 32'(data_avail), 32'h1);
        chk("press wait_led", 32'(wait_led), 32'h0);
        sw_enter = 1'b0;
        cyc(8);
        rd(1'b0);
        chk("first read", rd_data, 32'h00000001);
        chk("drained data_avail", 32'(data_avail), 32'h0);

        // Short glitches never debounce
        for (int i = 0; i < 5; i++) begin
            sw_enter = 1'b1;
            cyc(3);
            sw_enter = 1'b0;
            cyc(3);
        end
        cyc(4);
        rd(1'b1);
        chk("glitch status", rd_data, 32'h00000001);

        // Five presses into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) press(DW'(i));
        rd(1'b1);
        chk("overflow status", rd_data, 32'h00000406);
        for (int i = 1; i <= 4; i++) begin
            rd(1'b0);
            chk("ordered read", rd_data, 32'(i));
        end
        rd(1'b0);
        chk("empty read", rd_data, 32'h0);

        // Full FIFO, push coincides with pop
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        for (int i = 1; i <= 4; i++) press(DW'(16 + i));
        sw_data = 16'h0015;
        sw_enter = 1'b1;
        cyc(5);
        rd_en = 1'b1;
        rd_addr = 1'b0;
        cyc(1);
        rd_en = 1'b0;
        chk("full push+pop head", rd_data, 32'h00000011);
        rd(1'b1);
        chk("full push+pop status", rd_data, 32'h0000040A);
        sw_enter = 1'b0;
        cyc(8);

        // Overflow set beats simultaneous clear
        press(16'h0016);
        sw_data = 16'h0017;
        sw_enter = 1'b1;
        cyc(5);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        sw_enter = 1'b0;
        cyc(8);
        rd(1'b1);
        chk("ovf set wins", rd_data, 32'h00000406);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        rd(1'b1);
        chk("ovf cleared", rd_data, 32'h00000402);
        for (int i = 2; i <= 5; i++) begin
            rd(1'b0);
            chk("wrap read", rd_data, 32'(16 + i));
        end

        // Reset mid-debounce with two words queued
        press(16'h0021);
        press(16'h0022);
        rd(1'b1);
        chk("two queued status", rd_data, 32'h00000200);
        sw_enter = 1'b1;
        cyc(3);
        rst = 1'b1;
        #1;
        chk("async rst rd_data", rd_data, 32'h0);
        chk("async rst data_avail", 32'(data_avail), 32'h0);
        chk("async rst wait_led", 32'(wait_led), 32'h1);
        cyc(1);
        rst = 1'b0;
        cyc(5);
        chk("no push at 5", 32'(data_avail), 32'h0);
        cyc(1);
        chk("push at 6", 32'(data_avail), 32'h1);
        chk("push at 6 wait_led", 32'(wait_led), 32'h0);
        rd(1'b0);
        chk("post-reset word", rd_data, 32'h00000022);
        sw_enter = 1'b0;
        cyc(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
